// File: rtl/debounce_bank.sv
// ============================================================================
// Module   : debounce_bank
// Brief    : Multi-channel push-button debouncer with press/release strobes and
//            optional hold-to-repeat (compile with DEBOUNCE_REPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bank #(
    parameter int CHANNELS   = 5,
    parameter int CNT_W      = 16,
    parameter int REP_W      = 24,
    parameter int REP_DELAY  = 12500000,
    parameter int REP_PERIOD = 3125000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] d,
    output logic [CHANNELS-1:0] qs,
    output logic [CHANNELS-1:0] qp,
    output logic [CHANNELS-1:0] qr,
    output logic [CHANNELS-1:0] qrep,
    output logic                qp_any
);

    localparam longint c_rep_max = (64'd1 << REP_W) - 64'd1;

    // Repeat timing must fit the repeat counter even when repeat is not built.
    if ((REP_DELAY < 1) || (REP_PERIOD < 1) ||
        (longint'(REP_DELAY) > c_rep_max) || (longint'(REP_PERIOD) > c_rep_max)) begin : g_bad_rep_cfg
        $error("debounce_bank: REP_DELAY/REP_PERIOD out of range for REP_W");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        logic [1:0]       r_sync;
        logic [CNT_W-1:0] r_cnt;
        logic             r_qs;
        logic             r_qp;
        logic             r_qr;
        logic             r_qrep;

        logic             w_samp;
        logic             w_diff;
        logic             w_accept;
        logic             w_press;
        logic             w_release;
        logic             w_rep_fire;

        assign w_samp    = r_sync[1];
        assign w_diff    = w_samp ^ r_qs;
        assign w_accept  = w_diff & (r_cnt == {CNT_W{1'b1}});
        assign w_press   = w_accept & ~r_qs;
        assign w_release = w_accept &  r_qs;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= 2'b00;
                r_cnt  <= '0;
                r_qs   <= 1'b0;
                r_qp   <= 1'b0;
                r_qr   <= 1'b0;
                r_qrep <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], d[i]};
                // Any matching sample throws away the whole run.
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= '0;
                    r_qs  <= ~r_qs;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_qp   <= w_press | w_rep_fire;
                r_qr   <= w_release;
                r_qrep <= w_rep_fire;
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam logic [1:0] S_IDLE   = 2'd0;
        localparam logic [1:0] S_HELD   = 2'd1;
        localparam logic [1:0] S_REPEAT = 2'd2;

        localparam logic [REP_W-1:0] c_delay_m1  = REP_W'(REP_DELAY - 1);
        localparam logic [REP_W-1:0] c_period_m1 = REP_W'(REP_PERIOD - 1);

        logic [1:0]       r_state;
        logic [REP_W-1:0] r_rep_cnt;
        logic [1:0]       w_state_nxt;
        logic [REP_W-1:0] w_rep_cnt_nxt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state   <= S_IDLE;
                r_rep_cnt <= '0;
            end else begin
                r_state   <= w_state_nxt;
                r_rep_cnt <= w_rep_cnt_nxt;
            end
        end

        // Entering HELD on the accept edge lines the first repeat up REP_DELAY
        // cycles after the press strobe; release always wins over a repeat.
        always_comb begin
            w_state_nxt   = r_state;
            w_rep_cnt_nxt = r_rep_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        w_state_nxt   = S_HELD;
                        w_rep_cnt_nxt = '0;
                    end
                end
                S_HELD: begin
                    if (w_release) begin
                        w_state_nxt   = S_IDLE;
                        w_rep_cnt_nxt = '0;
                    end else if (r_rep_cnt == c_delay_m1) begin
                        w_state_nxt   = S_REPEAT;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (w_release) begin
                        w_state_nxt   = S_IDLE;
                        w_rep_cnt_nxt = '0;
                    end else if (r_rep_cnt == c_period_m1) begin
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_rep_cnt_nxt = '0;
                end
            endcase
        end

        always_comb begin
            w_rep_fire = 1'b0;
            case (r_state)
                S_HELD:   w_rep_fire = ~w_release & (r_rep_cnt == c_delay_m1);
                S_REPEAT: w_rep_fire = ~w_release & (r_rep_cnt == c_period_m1);
                default:  w_rep_fire = 1'b0;
            endcase
        end
`else
        assign w_rep_fire = 1'b0;
`endif

        assign qs[i]   = r_qs;
        assign qp[i]   = r_qp;
        assign qr[i]   = r_qr;
        assign qrep[i] = r_qrep;
    end

    assign qp_any = |qp;

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ============================================================================
// Module   : tb_debounce_bank
// Brief    : Self-checking bench for debounce_bank against a cycle-level
//            behavioural model; honours DEBOUNCE_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_bank;

    localparam int CH  = 3;
    localparam int CW  = 4;
    localparam int RW  = 8;
    localparam int RD  = 8;
    localparam int RP  = 4;
    localparam int ACC = 1 << CW;

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] d     = '0;
    logic [CH-1:0] qs;
    logic [CH-1:0] qp;
    logic [CH-1:0] qr;
    logic [CH-1:0] qrep;
    logic          qp_any;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS  (CH),
        .CNT_W     (CW),
        .REP_W     (RW),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .qs    (qs),
        .qp    (qp),
        .qr    (qr),
        .qrep  (qrep),
        .qp_any(qp_any)
    );

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    // Reference model: two-stage delayed sample, run length of disagreeing
    // samples, and an absolute cycle number for the next repeat.
    logic [CH-1:0] m_s1   = '0;
    logic [CH-1:0] m_s2   = '0;
    logic [CH-1:0] m_qs   = '0;
    logic [CH-1:0] m_qp   = '0;
    logic [CH-1:0] m_qr   = '0;
    logic [CH-1:0] m_qrep = '0;
    int            m_run  [CH];
    longint        m_next [CH];

    task automatic step();
        logic smp;
        @(posedge clk);
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (!rst_n) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_qs[c] = 1'b0;
                m_qp[c] = 1'b0; m_qr[c] = 1'b0; m_qrep[c] = 1'b0;
                m_run[c] = 0;   m_next[c] = -1;
            end else begin
                smp       = m_s2[c];
                m_s2[c]   = m_s1[c];
                m_s1[c]   = d[c];
                m_qp[c]   = 1'b0;
                m_qr[c]   = 1'b0;
                m_qrep[c] = 1'b0;
                if (smp != m_qs[c]) begin
                    m_run[c]++;
                    if (m_run[c] == ACC) begin
                        m_run[c] = 0;
                        m_qs[c]  = ~m_qs[c];
                        if (m_qs[c]) begin
                            m_qp[c]   = 1'b1;
                            m_next[c] = cyc + RD;
                        end else begin
                            m_qr[c]   = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (REP_ON && m_qs[c] && !m_qp[c] && cyc == m_next[c]) begin
                    m_qp[c]   = 1'b1;
                    m_qrep[c] = 1'b1;
                    m_next[c] = cyc + RP;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        d     = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d     = CH'($urandom);
        step();
        step();
        n_cmp++;
        if ({qs, qp, qr, qrep, qp_any} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got qs=%b qp=%b qr=%b qrep=%b any=%b want all 0",
                     qs, qp, qr, qrep, qp_any);
        end
        rst_n = 1'b1;
        d     = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
        end
    endtask

    task automatic test_single_press();
        int lat;
        lat = 0;
        apply_reset();
        d = 3'b001;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL press_model cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
            if (qs[0]) lat = k;
        end
        n_cmp++;
        if (lat != 2 + ACC) begin
            n_fail++;
            $display("FAIL press_latency got %0d edges want %0d", lat, 2 + ACC);
        end
        n_cmp++;
        if (qp !== 3'b001) begin
            n_fail++;
            $display("FAIL press_strobe got qp=%b want 001", qp);
        end
        step();
        n_cmp++;
        if (qp !== 3'b000 || qs !== 3'b001 || qr !== 3'b000) begin
            n_fail++;
            $display("FAIL press_one_cycle got qp=%b qs=%b qr=%b want 000/001/000", qp, qs, qr);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int k = 0; k < 200; k++) begin
            if (k % 10 == 0) d[1] = ~d[1];
            step();
            n_cmp++;
            if ({qs[1], qp[1], qr[1]} !== 3'b000 ||
                {qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d got qs=%b qp=%b qr=%b want ch1 quiet",
                         cyc, qs, qp, qr);
            end
        end
        d = '0;
    endtask

    task automatic test_simultaneous();
        int k_press;
        int k_rel;
        k_press = 0;
        k_rel   = 0;
        apply_reset();
        d = 3'b111;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL simul_hold cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
            if (k_press != 0 && k == k_press + 1) begin
                n_cmp++;
                if (qp_any !== 1'b0) begin
                    n_fail++;
                    $display("FAIL simul_any_width got qp_any=%b want 0", qp_any);
                end
            end
            if (qp != 0 && k_press == 0) begin
                k_press = k;
                n_cmp++;
                if (qp !== 3'b111 || qp_any !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_press got qp=%b any=%b want 111/1", qp, qp_any);
                end
            end
        end
        d = 3'b000;
        for (int k = 1; k <= 40 && k_rel == 0; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL simul_release cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
            if (qr != 0) begin
                k_rel = k;
                n_cmp++;
                if (qr !== 3'b111) begin
                    n_fail++;
                    $display("FAIL simul_qr got qr=%b want 111", qr);
                end
            end
        end
        n_cmp++;
        if (k_rel != 2 + ACC) begin
            n_fail++;
            $display("FAIL release_latency got %0d edges want %0d", k_rel, 2 + ACC);
        end
    endtask

    task automatic test_repeat();
        int n_qp;
        int n_rep;
        int first_rep;
        int after;
        bit up;
        n_qp = 0; n_rep = 0; first_rep = 0; after = 0; up = 1'b0;
        apply_reset();
        d = 3'b100;
        for (int k = 1; k <= 40 && !up; k++) begin
            step();
            if (qs[2]) up = 1'b1;
        end
        n_cmp++;
        if (!up || qp[2] !== 1'b1 || qrep[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_press got qs=%b qp=%b qrep=%b want qs2/qp2 set, qrep2 clear",
                     qs, qp, qrep);
        end
        n_qp = 1;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp} ||
                qrep[2] !== (qp[2] & REP_ON)) begin
                n_fail++;
                $display("FAIL repeat_hold cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
            if (qp[2]) n_qp++;
            if (qrep[2]) begin
                n_rep++;
                if (first_rep == 0) first_rep = k;
            end
        end
        n_cmp++;
        if (n_qp != (REP_ON ? 10 : 1) || n_rep != (REP_ON ? 9 : 0) ||
            first_rep != (REP_ON ? RD : 0)) begin
            n_fail++;
            $display("FAIL repeat_count got qp=%0d qrep=%0d first=%0d want %0d/%0d/%0d",
                     n_qp, n_rep, first_rep, REP_ON ? 10 : 1, REP_ON ? 9 : 0, REP_ON ? RD : 0);
        end
        d = 3'b000;
        for (int k = 1; k <= 60 && qs[2]; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL repeat_release cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (qp[2] || qrep[2]) after++;
        end
        n_cmp++;
        if (qs[2] !== 1'b0 || after != 0) begin
            n_fail++;
            $display("FAIL repeat_stop got qs2=%b strobes=%0d want 0/0", qs[2], after);
        end
    endtask

    task automatic test_reset_midcount();
        int lat;
        lat = 0;
        apply_reset();
        d = 3'b001;
        for (int k = 0; k < 12; k++) step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({qs, qp, qr, qrep, qp_any} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got qs=%b qp=%b qr=%b qrep=%b any=%b want all 0",
                     qs, qp, qr, qrep, qp_any);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            n_cmp++;
            if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                n_fail++;
                $display("FAIL midreset_model cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
            end
            if (qs[0]) lat = k;
        end
        n_cmp++;
        if (lat != 2 + ACC) begin
            n_fail++;
            $display("FAIL midreset_latency got %0d edges want %0d", lat, 2 + ACC);
        end
    endtask

    task automatic test_random();
        int hold;
        apply_reset();
        for (int seg = 0; seg < 150; seg++) begin
            d    = CH'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 60)
                                               : $urandom_range(1, 20);
            if ($urandom_range(0, 29) == 0) rst_n = 1'b0;
            for (int k = 0; k < hold; k++) begin
                step();
                rst_n = 1'b1;
                n_cmp++;
                if ({qs, qp, qr, qrep, qp_any} !== {m_qs, m_qp, m_qr, m_qrep, |m_qp}) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                             cyc, qs, qp, qr, qrep, qp_any, m_qs, m_qp, m_qr, m_qrep, |m_qp);
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_next[c] = -1;
        end
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_repeat();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
